// File: rtl/nexi_uart_pkg.sv
// Purpose: shared register indices, STATUS/IER bit positions and FSM encodings for the nexi UART.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package nexi_uart_pkg;

    localparam int OVERSAMPLE = 16;
    // Per-state tick counter terminal values: end of a full bit, and mid-bit of the start bit.
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DIV    = 3'd2;
    localparam logic [2:0] REG_IER    = 3'd3;
    localparam logic [2:0] REG_ISR    = 3'd4;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_BUSY  = 3;
    localparam int ST_RXOVR    = 4;
    localparam int ST_FERR     = 5;
    localparam int ST_TXOVF    = 6;

    localparam int IER_RX  = 0;
    localparam int IER_TX  = 1;
    localparam int IER_ERR = 2;

    // Shared by the TX and RX frame state machines.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/nexi_uart_sync_fifo.sv
// Purpose: single-clock FIFO with wrap-bit pointers; level = wr - rd.
// Latency: push visible on data_o/empty_o the cycle after the push edge; data_o is the head (show-ahead).
// Backpressure: push into a full FIFO is dropped unless a pop happens the same cycle; pop of empty is ignored.
// Ports: clk_i/rst_i (sync, active-high), push_i/data_i, pop_i/data_o, full_o, empty_o, level_o.
module nexi_uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so push+pop on a full FIFO is legal.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/nexi_uart_fifo_wb.sv
// Purpose: Wishbone UART with TX/RX FIFOs, programmable divisor, 16x oversampled RX, sticky errors, level irq.
// Latency: every bus access acks one cycle after it is presented; irq_o lags the ISR by one cycle.
// Backpressure: TX write to a full FIFO drops the byte (TXOVF); RX byte into a full FIFO is dropped (RXOVR).
// Ports: clk_i/rst_i, Wishbone slave (cyc_i, stb_i, we_i, addr_i, data_i, sel_i, ack_o, data_o), irq_o, rx_pin, tx_pin.
module nexi_uart_fifo_wb
    import nexi_uart_pkg::*;
#(
    parameter int          TX_DEPTH    = 16,
    parameter int          RX_DEPTH    = 16,
    parameter int          DATA_BITS   = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic [31:0] data_o,
    output logic        irq_o,
    input  logic        rx_pin,
    output logic        tx_pin
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Bus / register state
    logic                 ack_q, irq_q;
    logic [31:0]          rdat_q, rd_val, status;
    logic [15:0]          div_q, tick_cnt_q;
    logic [2:0]           ier_q, isr;
    logic                 rxovr_q, ferr_q, txovf_q;
    logic                 acc, bus_wr, bus_rd, tick, err_clr;
    logic                 tx_wr, rx_pop, txovf_set, rxovr_set, ferr_set;
    // FIFOs
    logic                 tx_pop, tx_full, tx_empty, rx_push, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_dout, rx_dout;
    logic [$clog2(TX_DEPTH):0] tx_level;
    logic [$clog2(RX_DEPTH):0] rx_level;
    // TX FSM
    uart_state_e          tx_state_q, tx_state_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d, tx_busy;
    // RX FSM
    uart_state_e          rx_state_q, rx_state_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    logic                 unused_bits;

    assign unused_bits = ^{sel_i, data_i[31:16]};

    assign acc     = cyc_i && stb_i && !ack_q;
    assign bus_wr  = acc && we_i;
    assign bus_rd  = acc && !we_i;
    assign tx_wr   = bus_wr && (addr_i == REG_DATA);
    assign rx_pop  = bus_rd && (addr_i == REG_DATA) && !rx_empty;
    assign err_clr = bus_wr && (addr_i == REG_ISR) && data_i[IER_ERR];
    assign txovf_set = tx_wr && tx_full && !tx_pop;
    assign tick    = (tick_cnt_q == div_q);
    assign tx_busy = (tx_state_q != S_IDLE);
    assign rx_fall = rx_s3_q && !rx_s2_q;

    assign isr = {rxovr_q | ferr_q | txovf_q, tx_empty & ~tx_busy, ~rx_empty} & ier_q;

    always_comb begin
        status              = '0;
        status[ST_RX_AVAIL] = !rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_RXOVR]    = rxovr_q;
        status[ST_FERR]     = ferr_q;
        status[ST_TXOVF]    = txovf_q;
        status[15:8]        = 8'(rx_level);
        status[23:16]       = 8'(tx_level);
    end

    always_comb begin
        rd_val = '0;
        case (addr_i)
            REG_DATA:   rd_val = rx_empty ? 32'd0 : 32'(rx_dout);
            REG_STATUS: rd_val = status;
            REG_DIV:    rd_val = {16'd0, div_q};
            REG_IER:    rd_val = {29'd0, ier_q};
            REG_ISR:    rd_val = {29'd0, isr};
            default:    rd_val = '0;
        endcase
    end

    nexi_uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_wr), .data_i(data_i[DATA_BITS-1:0]),
        .pop_i(tx_pop), .data_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
    );

    nexi_uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push), .data_i(rx_shift_q),
        .pop_i(rx_pop), .data_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
    );

    // TX: each state lasts OVERSAMPLE ticks; back-to-back frames skip IDLE.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_cnt_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == TICK_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == TICK_LAST) begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 3'd1;
                        if (tx_bit_q == LAST_BIT) tx_state_d = S_STOP;
                    end
                end
            end
            default: begin // S_STOP
                if (tick) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == TICK_LAST) begin
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_dout;
                            tx_state_d = S_START;
                        end else begin
                            tx_state_d = S_IDLE;
                        end
                    end
                end
            end
        endcase
        // Line level is registered from the next state so tx_pin never glitches on decode.
        tx_d = (tx_state_d == S_START) ? 1'b0 : (tx_state_d == S_DATA) ? tx_shift_d[0] : 1'b1;
    end

    // RX: start validated at mid-start, data sampled every OVERSAMPLE ticks from there.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rxovr_set  = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == TICK_MID) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == TICK_LAST) begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == LAST_BIT) rx_state_d = S_STOP;
                    end
                end
            end
            default: begin // S_STOP
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == TICK_LAST) begin
                        rx_state_d = S_IDLE;
                        if (!rx_s2_q)                ferr_set  = 1'b1;
                        else if (rx_full && !rx_pop) rxovr_set = 1'b1;
                        else                         rx_push   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            irq_q      <= 1'b0;
            div_q      <= DEFAULT_DIV;
            tick_cnt_q <= '0;
            ier_q      <= '0;
            rxovr_q    <= 1'b0;
            ferr_q     <= 1'b0;
            txovf_q    <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
        end else begin
            ack_q  <= acc;
            rdat_q <= bus_rd ? rd_val : 32'd0;
            irq_q  <= |isr;
            if (bus_wr && addr_i == REG_DIV) begin
                div_q      <= data_i[15:0];
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
            end
            if (bus_wr && addr_i == REG_IER) ier_q <= data_i[2:0];
            // A new error wins over a same-cycle clear.
            rxovr_q    <= (rxovr_q & ~err_clr) | rxovr_set;
            ferr_q     <= (ferr_q  & ~err_clr) | ferr_set;
            txovf_q    <= (txovf_q & ~err_clr) | txovf_set;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= rx_pin;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdat_q;
    assign irq_o  = irq_q;
    assign tx_pin = tx_q;

endmodule

// File: tb/tb_nexi_uart_fifo_wb.sv
// Purpose: directed self-checking bench for nexi_uart_fifo_wb; reads and TX frames are checked by scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_nexi_uart_fifo_wb;
    localparam logic [2:0] A_DATA = 3'd0, A_STATUS = 3'd1, A_DIV = 3'd2, A_IER = 3'd3, A_ISR = 3'd4;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [2:0]  addr;
    logic [31:0] wdat, rdat;
    logic [3:0]  sel;
    logic        ack, irq, rx_pin, tx_pin;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic [7:0]  txexp_q[$];
    int          txstart_q[$];
    bit          tx_mon_en = 1'b0;

    nexi_uart_fifo_wb #(.TX_DEPTH(16), .RX_DEPTH(16), .DATA_BITS(8), .DEFAULT_DIV(16'd26)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .addr_i(addr),
        .data_i(wdat), .sel_i(sel), .ack_o(ack), .data_o(rdat), .irq_o(irq),
        .rx_pin(rx_pin), .tx_pin(tx_pin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, got, exp);
        end
    endtask

    // Read scoreboard: every acked read pops one expectation.
    logic [31:0] mon_e;
    string       mon_n;
    always begin
        @(posedge clk);
        #2;
        if (ack === 1'b1 && we === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got 0x%08h, want no read", rdat);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = nm_q.pop_front();
                chk(mon_n, rdat, mon_e);
            end
        end
    end

    // TX frame scoreboard: sample each bit near its start and near its end.
    logic       tx_prev = 1'b1;
    logic [9:0] fr_lo, fr_hi;
    logic [7:0] tx_e;
    always begin
        @(negedge clk);
        if (tx_mon_en && tx_prev === 1'b1 && tx_pin === 1'b0) begin
            txstart_q.push_back(cycle);
            fr_lo = '0;
            fr_hi = '0;
            for (int r = 1; r < 160; r++) begin
                @(negedge clk);
                if (r % 16 == 1)  fr_lo[r / 16] = tx_pin;
                if (r % 16 == 14) fr_hi[r / 16] = tx_pin;
            end
            tx_prev = tx_pin;
            if (txexp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got frame 0x%03h, want none", fr_lo);
            end else begin
                tx_e = txexp_q.pop_front();
                chk("tx_frame_early", {22'd0, fr_lo}, {22'd0, 1'b1, tx_e, 1'b0});
                chk("tx_frame_late",  {22'd0, fr_hi}, {22'd0, 1'b1, tx_e, 1'b0});
            end
        end else begin
            tx_prev = tx_pin;
        end
    end

    task automatic wb(input logic w, input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
        @(negedge clk);
        while (ack !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (ack !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wb_ack_timeout: got ack=%b, want 1", ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        wb(1'b0, a, 32'd0);
    endtask

    // One serial character: start, 8 data LSB first, stop.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int bclk);
        rx_pin = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (bclk) @(negedge clk);
        end
        rx_pin = stop_bit;
        repeat (bclk) @(negedge clk);
        rx_pin = 1'b1;
    endtask

    logic [7:0] ob;
    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0; sel = 4'hF; rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_data_o", rdat, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        // Only tx_empty is set out of reset.
        rd(A_STATUS, 32'h0000_0004, "rst_status");
        rd(A_DIV, 32'h0000_001A, "rst_div");
        rd(A_IER, 32'h0, "rst_ier");
        rd(3'd5, 32'h0, "unmapped_read");

        // TX: two back-to-back frames at 16 clocks per bit.
        wb(1'b1, A_DIV, 32'd0);
        tx_mon_en = 1'b1;
        txexp_q.push_back(8'h55);
        txexp_q.push_back(8'hA3);
        wb(1'b1, A_DATA, 32'h55);
        wb(1'b1, A_DATA, 32'hA3);
        repeat (200) @(negedge clk);
        rd(A_STATUS, 32'h0000_000C, "tx_second_frame_busy");
        repeat (150) @(negedge clk);
        rd(A_STATUS, 32'h0000_0004, "tx_done_status");
        tx_mon_en = 1'b0;
        chk("tx_frame_count", txstart_q.size(), 32'd2);
        if (txstart_q.size() >= 2)
            chk("tx_no_gap", 32'(txstart_q[1] - txstart_q[0]), 32'd160);

        // RX: one byte at 64 clocks per bit.
        wb(1'b1, A_DIV, 32'd3);
        rd(A_DIV, 32'd3, "div_readback");
        send_rx(8'h3C, 1'b1, 64);
        repeat (10) @(negedge clk);
        rd(A_STATUS, 32'h0000_0105, "rx_one_status");
        rd(A_DATA, 32'h3C, "rx_one_data");
        rd(A_STATUS, 32'h0000_0004, "rx_one_drained");
        rd(A_DATA, 32'h0, "rx_empty_read");

        // Overrun: 17 characters into a 16-deep FIFO, the last is lost.
        for (int i = 0; i < 17; i++) begin
            ob = 8'(i * 37 + 5);
            send_rx(ob, 1'b1, 64);
        end
        repeat (10) @(negedge clk);
        rd(A_STATUS, 32'h0000_1015, "rx_overrun_status");
        for (int i = 0; i < 16; i++) begin
            ob = 8'(i * 37 + 5);
            rd(A_DATA, {24'd0, ob}, "rx_fifo_order");
        end
        rd(A_STATUS, 32'h0000_0014, "rx_after_drain");
        wb(1'b1, A_ISR, 32'h4);
        rd(A_STATUS, 32'h0000_0004, "rxovr_cleared");

        // Framing error: stop bit low, nothing pushed.
        send_rx(8'h5A, 1'b0, 64);
        repeat (10) @(negedge clk);
        rd(A_STATUS, 32'h0000_0024, "ferr_status");
        wb(1'b1, A_ISR, 32'h4);
        // Short low pulse rejected at mid-start.
        rx_pin = 1'b0;
        repeat (16) @(negedge clk);
        rx_pin = 1'b1;
        repeat (700) @(negedge clk);
        rd(A_STATUS, 32'h0000_0004, "glitch_ignored");

        // Interrupts.
        wb(1'b1, A_IER, 32'h1);
        repeat (3) @(negedge clk);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        send_rx(8'h81, 1'b1, 64);
        repeat (4) @(negedge clk);
        chk("irq_rx_avail", {31'd0, irq}, 32'd1);
        rd(A_ISR, 32'h1, "isr_rx");
        rd(A_DATA, 32'h81, "irq_data");
        repeat (2) @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        wb(1'b1, A_IER, 32'h2);
        repeat (3) @(negedge clk);
        chk("irq_tx_empty", {31'd0, irq}, 32'd1);
        rd(A_ISR, 32'h2, "isr_tx");
        wb(1'b1, A_IER, 32'h0);

        // TX overflow: the transmitter takes byte 0 at once, so the 18th write is the first dropped.
        wb(1'b1, A_DIV, 32'd100);
        for (int i = 0; i < 17; i++) wb(1'b1, A_DATA, 32'(i));
        rd(A_STATUS, 32'h0010_000A, "tx_full_status");
        wb(1'b1, A_DATA, 32'h11);
        rd(A_STATUS, 32'h0010_004A, "txovf_status");

        // Reset in the middle of the start bit.
        chk("tx_midframe_low", {31'd0, tx_pin}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("tx_reset_high", {31'd0, tx_pin}, 32'd1);
        rst = 1'b0;
        rd(A_STATUS, 32'h0000_0004, "post_reset_status");
        rd(A_DIV, 32'h0000_001A, "post_reset_div");

        repeat (5) @(negedge clk);
        chk("rd_scoreboard_empty", exp_q.size(), 32'd0);
        chk("tx_scoreboard_empty", txexp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
